// File: rtl/jpeg_pkg.sv
// jpeg_pkg
// Shared constants and the FSM state type for the JPEG byte stuffer.
//   JPEG_FF      marker prefix byte; a data FF is followed by JPEG_STUFF
//   JPEG_STUFF   byte inserted after a data FF
//   JPEG_EOI_LO  second byte of the EOI marker (FF D9)
package jpeg_pkg;

  localparam logic [7:0] JPEG_FF     = 8'hFF;
  localparam logic [7:0] JPEG_STUFF  = 8'h00;
  localparam logic [7:0] JPEG_EOI_LO = 8'hD9;

  typedef enum logic [2:0] {
    IDLE,
    BYTE,
    STUFF,
    EOI_FF,
    EOI_D9
  } stuff_state_t;

endpackage

// File: rtl/jpeg_sync_fifo.sv
// jpeg_sync_fifo
// Single-clock FIFO with combinational read of the head entry.
// Pointers carry one extra wrap bit so full and empty are told apart.
//   clk_i   clock
//   rst_i   asynchronous active-high reset (empties the FIFO)
//   push    write wdata when not full (ignored when full)
//   wdata   write data
//   pop     drop head entry when not empty
//   rdata   head entry (valid when empty=0)
//   full    DEPTH entries held
//   empty   no entries held
module jpeg_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jpeg_byte_stuffer.sv
// jpeg_byte_stuffer
// Serialises entropy-coded words MSB byte first, escapes every data FF with
// a following 00 and appends EOI (FF D9) once a frame's words are drained.
//   clk_i, rst_i     clock, asynchronous active-high reset
//   word_i/_valid_i  coded word in (no backpressure upstream)
//   word_ready_o     input FIFO not full (advisory)
//   frame_end_i      pulse: emit EOI after all words delivered so far
//   byte_o/_valid_o  output byte stream, byte_ready_i from the sink
//   frame_done_o     pulse the cycle after the D9 byte is accepted
//   ovf_o            sticky: a word arrived while the FIFO was full
//   busy_o           any word, byte or EOI still in flight
//
// state  | meaning
// IDLE   | nothing being serialised; load next word or start EOI
// BYTE   | offering byte shreg[top] of the current word
// STUFF  | offering the 00 that follows a data FF
// EOI_FF | offering the FF of the EOI marker (not stuffed)
// EOI_D9 | offering the D9 of the EOI marker
module jpeg_byte_stuffer
  import jpeg_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  input  logic              frame_end_i,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic              frame_done_o,
  output logic              ovf_o,
  output logic              busy_o
);

  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  stuff_state_t      state, state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        cur_byte;
  logic              eoi_pend;
  logic              last_d9;

  logic [WORD_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  logic              out_ready;
  logic              out_load;
  logic [7:0]        out_data;
  logic              out_is_d9;
  logic              load_word;
  logic              shift_byte;
  logic              advance;
  logic              clr_eoi;

  jpeg_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (word_valid_i),
    .wdata (word_i),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign word_ready_o = ~fifo_full;
  assign cur_byte     = shreg[WORD_W-1 -: 8];
  // The output byte sits in a register slice; the FSM may hand it a new
  // byte whenever the slice is empty or being drained this cycle.
  assign out_ready    = ~byte_valid_o | byte_ready_i;
  assign busy_o       = ~fifo_empty | (state != IDLE) | eoi_pend | byte_valid_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_pop   = 1'b0;
    load_word  = 1'b0;
    shift_byte = 1'b0;
    advance    = 1'b0;
    out_load   = 1'b0;
    out_data   = '0;
    out_is_d9  = 1'b0;
    clr_eoi    = 1'b0;
    case (state)
      IDLE: begin
        // Queued words always go before the EOI marker.
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load_word = 1'b1;
          state_nxt = BYTE;
        end else if (eoi_pend) begin
          state_nxt = EOI_FF;
        end
      end
      BYTE: begin
        if (out_ready) begin
          out_load = 1'b1;
          out_data = cur_byte;
          if (cur_byte == JPEG_FF) state_nxt = STUFF;
          else                     advance   = 1'b1;
        end
      end
      STUFF: begin
        if (out_ready) begin
          out_load  = 1'b1;
          out_data  = JPEG_STUFF;
          state_nxt = BYTE;
          advance   = 1'b1;
        end
      end
      EOI_FF: begin
        if (out_ready) begin
          out_load  = 1'b1;
          out_data  = JPEG_FF;
          state_nxt = EOI_D9;
        end
      end
      EOI_D9: begin
        if (out_ready) begin
          out_load  = 1'b1;
          out_data  = JPEG_EOI_LO;
          out_is_d9 = 1'b1;
          clr_eoi   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Post-byte step: next byte of this word, or chain straight into the
    // next queued word so back-to-back words leave no idle cycle.
    if (advance) begin
      if (idx == LAST_IDX) begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load_word = 1'b1;
          state_nxt = BYTE;
        end else begin
          state_nxt = IDLE;
        end
      end else begin
        shift_byte = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load_word) begin
      shreg <= fifo_rdata;
      idx   <= '0;
    end else if (shift_byte) begin
      shreg <= shreg << 8;
      idx   <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      last_d9      <= 1'b0;
    end else if (out_load) begin
      byte_o       <= out_data;
      byte_valid_o <= 1'b1;
      last_d9      <= out_is_d9;
    end else if (byte_ready_i) begin
      byte_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      eoi_pend     <= 1'b0;
      ovf_o        <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      if (clr_eoi)                      eoi_pend <= 1'b0;
      else if (frame_end_i && !eoi_pend) eoi_pend <= 1'b1;
      if (word_valid_i && fifo_full) ovf_o <= 1'b1;
      frame_done_o <= byte_valid_o & byte_ready_i & last_d9;
    end
  end

endmodule
